// File: rtl/dmem_responder.sv
// Data-memory responder: 256x32 RAM plus a memory-mapped 4-deep TX FIFO
// with a status register, decoded on the full byte address.
module dmem_responder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        stall,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [31:0] TXDATA_ADDR = 32'h0000_8000;
    localparam logic [31:0] STATUS_ADDR = 32'h0000_8004;

    logic [31:0] ram_r  [0:255];
    logic [31:0] fifo_r [0:3];
    logic [1:0]  rptr_r;
    logic [1:0]  wptr_r;
    logic [2:0]  count_r;
    logic [15:0] tx_total_r;

    logic ram_sel_s;
    logic tx_sel_s;
    logic st_sel_s;
    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic ram_we_s;

    // Address decode, FIFO flags and transfer strobes.
    always_comb begin
        ram_sel_s = (addr[31:10] == 22'd0);
        tx_sel_s  = (addr == TXDATA_ADDR);
        st_sel_s  = (addr == STATUS_ADDR);
        full_s    = (count_r == 3'd4);
        empty_s   = (count_r == 3'd0);
        // A pop in the same edge frees the slot, so a full FIFO only stalls without tx_ready.
        stall     = we & tx_sel_s & full_s & ~tx_ready;
        push_s    = we & tx_sel_s & ~stall;
        pop_s     = ~empty_s & tx_ready;
        ram_we_s  = we & ram_sel_s & ~stall;
        tx_valid  = ~empty_s;
        tx_data   = fifo_r[rptr_r];
    end

    // Load data mux.
    always_comb begin
        rdata = 32'd0;
        if (ram_sel_s) begin
            rdata = ram_r[addr[9:2]];
        end else if (st_sel_s) begin
            rdata = {tx_total_r, 11'd0, full_s, empty_s, count_r};
        end else begin
            rdata = 32'd0;
        end
    end

    // RAM array; intentionally not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[addr[9:2]] <= wdata;
        end
    end

    // TX FIFO pointers, occupancy, storage and popped-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_r     <= 2'd0;
            wptr_r     <= 2'd0;
            count_r    <= 3'd0;
            tx_total_r <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                fifo_r[wptr_r] <= wdata;
                wptr_r         <= wptr_r + 2'd1;
            end
            if (pop_s) begin
                rptr_r     <= rptr_r + 2'd1;
                tx_total_r <= tx_total_r + 16'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have the following ports, one clock and one reset, with clock and reset listed first.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- addr  input  WORD (32)  byte address from the core's ALU result.
- wdata  input  WORD (32)  store data from the core.
- we  input  1  store strobe (memWrite).
- rdata  output  WORD (32)  load data to the core (readData); combinational.
- stall  output  1  store cannot be accepted this cycle; the core holds the instruction.
- tx_data  output  WORD (32)  head word of the TX FIFO.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  downstream consumer accepts tx_data.

Function
REQ-002 The address map SHALL be decoded on full addr:
- RAM: 0x0000_0000–0x0000_03FF; word index addr[9:2]; addr[1:0] ignored.
- TXDATA: 0x0000_8000.
- STATUS: 0x0000_8004.
- All other addresses: unmapped.
REQ-003 RAM SHALL be 256 x 32 with a combinational read and a write on the rising edge when we=1, RAM is selected and stall=0.
REQ-004 RAM contents SHALL NOT be reset.
REQ-005 rdata SHALL be:
- RAM word when RAM is selected;
- {tx_total[15:0], 11'b0, full, empty, count[2:0]} for STATUS;
- 0 for TXDATA and unmapped addresses.
REQ-006 The TX FIFO SHALL be 4 deep, with 2-bit read/write pointers that wrap 3->0 and a 3-bit count in the range 0..4.
- empty = (count==0); full = (count==4).
REQ-007 tx_valid SHALL equal !empty; tx_data SHALL equal the entry at the read pointer.
REQ-008 tx_data SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-009 A pop SHALL occur on a rising edge with tx_valid=1 and tx_ready=1.
- Pop advances the read pointer and increments tx_total.
- tx_total is a 16-bit counter that wraps 0xFFFF->0x0000.
REQ-010 A push SHALL occur on a rising edge with we=1, TXDATA selected and stall=0.
- Push writes wdata at the write pointer and advances it.
REQ-011 stall SHALL equal we & TXDATA-selected & full & !tx_ready, and SHALL be 0 for all other accesses.
REQ-012 Simultaneous push and pop SHALL both take effect and leave count unchanged, including when full.
REQ-013 There SHALL be no fall-through: a word pushed into an empty FIFO appears on tx_valid one cycle after the push edge.
REQ-014 Writes to STATUS and unmapped addresses SHALL be ignored with stall=0; reads SHALL have no side effects.
REQ-015 Latency:
- RAM store is visible to a load in the cycle after the write edge.
- TX push to tx_valid is 1 cycle.
- STATUS reflects the state after the most recent edge.

Reset
REQ-016 While rst_n=0, regardless of clk, the block SHALL hold:
- pointers, count and tx_total = 0;
- tx_valid = 0, stall = 0, rdata(STATUS) = 0x0000_0008 (empty=1).
REQ-017 Reset asserted mid-operation SHALL discard all FIFO contents and SHALL NOT alter RAM.
REQ-018 The first push or pop SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0013 -> rdata=0xDEADBEEF; load 0x0000_0014 -> not 0xDEADBEEF-affected word.
- tx_ready=0, push 0x11,0x22,0x33,0x44 -> STATUS=0x0000_0014 (full, count 4); fifth push 0x55 -> stall=1 and the FIFO is unchanged.
- Full FIFO, tx_ready=1, push 0x55 -> stall=0; tx_data 0x11 popped; count stays 4; pop order 0x22,0x33,0x44,0x55.
- Push 0xA, tx_ready=1 -> tx_valid rises 1 cycle later, pops next edge; STATUS[31:16] increments to 1; 8 more push/pop pairs exercise pointer wrap with data order preserved.
- Preload tx_total=0xFFFF by 65535 pops, then one more pop -> STATUS[31:16]=0x0000.
- Mid-stream rst_n low asynchronously with count=3 -> tx_valid=0 immediately; after release STATUS=0x0000_0008 and RAM word 0x10 is still 0xDEADBEEF.
